// File: rtl/sl_bus_arbiter_pkg.sv
// Shared encodings for the slave-bus arbiter and the output bus mux that decodes grant_idx.
package sl_bus_arbiter_pkg;
  localparam int ARB_IDX_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/sl_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching last+1, last+2, ... (wrapping).
module rr_pick
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [ARB_IDX_W-1:0] i_last,
  output logic [NUM_REQ-1:0]   o_onehot,
  output logic [ARB_IDX_W-1:0] o_idx,
  output logic                 o_any
);
  int w_dist;
  int w_best;

  always_comb begin
    w_dist   = 0;
    w_best   = NUM_REQ;
    o_idx    = '0;
    o_onehot = '0;
    // distance 0 is the requester right after the previous winner
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + 2 * NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = ARB_IDX_W'(i);
      end
    end
    o_any = |i_req;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_onehot[i] = o_any && (o_idx == ARB_IDX_W'(i));
    end
  end
endmodule

// File: rtl/sl_bus_arbiter.sv
// Round-robin arbiter for the shared slave output bus; grant held until release, then GAP_CYCLES idle.
// Optional forced revoke of long grants when SL_ARB_TIMEOUT_EN is defined.
//   state     | meaning
//   ARB_IDLE  | no owner, arbitrate every cycle
//   ARB_GRANT | owner holds the bus until it drops req (or is revoked)
//   ARB_GAP   | bus idle after release, arbitrates on the last gap cycle
module sl_bus_arbiter
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
`ifdef SL_ARB_TIMEOUT_EN
  ,
  parameter int HOLD_MAX   = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ARB_IDX_W-1:0] grant_idx,
  output logic                 busy,
  output logic                 hold_timeout
);
  localparam logic [3:0]           GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam logic [ARB_IDX_W-1:0] LAST_RST = ARB_IDX_W'(NUM_REQ - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [ARB_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [ARB_IDX_W-1:0] r_last, w_last_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [3:0]           r_gap_cnt, w_gap_nxt;
  logic                 w_arb, w_release;
  logic                 w_owner_req, w_hold_done;
  logic [NUM_REQ-1:0]   w_elig, w_pick;
  logic [ARB_IDX_W-1:0] w_pick_idx;
  logic                 w_pick_any;

  assign w_owner_req = |(req & r_grant);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (w_elig),
    .i_last   (r_last),
    .o_onehot (w_pick),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

`ifdef SL_ARB_TIMEOUT_EN
  logic [15:0]        r_hold_cnt;
  logic [NUM_REQ-1:0] r_mask;
  logic               r_timeout;
  logic               w_revoke;

  assign w_hold_done  = (r_hold_cnt == 16'(HOLD_MAX - 1));
  assign w_revoke     = (r_state == ARB_GRANT) && w_owner_req && w_hold_done;
  assign w_elig       = req & ~r_mask;
  assign hold_timeout = r_timeout;

  // a revoked owner stays masked until its request is seen low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_mask     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_revoke;
      r_mask    <= (r_mask & req) | (w_revoke ? r_grant : '0);
      if (w_arb && w_pick_any) r_hold_cnt <= '0;
      else if (r_state == ARB_GRANT) r_hold_cnt <= r_hold_cnt + 16'd1;
    end
  end
`else
  assign w_hold_done  = 1'b0;
  assign w_elig       = req;
  assign hold_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_last    <= LAST_RST;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_last    <= w_last_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_last_nxt  = r_last;
    w_gap_nxt   = r_gap_cnt;
    w_arb       = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ARB_IDLE:  w_arb = 1'b1;
      ARB_GRANT: if (!w_owner_req || w_hold_done) w_release = 1'b1;
      // arbitrating on the final gap cycle keeps the idle time at exactly GAP_CYCLES
      ARB_GAP: begin
        if (r_gap_cnt == 4'd0) w_arb = 1'b1;
        else w_gap_nxt = r_gap_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
    if (w_arb) begin
      w_state_nxt = ARB_IDLE;
      if (w_pick_any) begin
        w_state_nxt = ARB_GRANT;
        w_grant_nxt = w_pick;
        w_idx_nxt   = w_pick_idx;
        w_busy_nxt  = 1'b1;
        w_last_nxt  = w_pick_idx;
      end
    end
    if (w_release) begin
      w_state_nxt = ARB_GAP;
      w_grant_nxt = '0;
      w_busy_nxt  = 1'b0;
      w_gap_nxt   = GAP_LOAD;
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign busy      = r_busy;
endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Bench for sl_bus_arbiter: instance a (GAP_CYCLES=1) and instance b (GAP_CYCLES=3, HOLD_MAX=16).
// Defining SL_ARB_TIMEOUT_EN also exercises forced revoke on instance b.
module tb_sl_bus_arbiter;
  logic       clk, reset;
  logic [3:0] req_a, req_b, grant_a, grant_b, req_sa;
  logic [2:0] idx_a, idx_b;
  logic       busy_a, busy_b, tmo_a, tmo_b;

  int n_chk = 0;
  int n_fail = 0;

`ifdef SL_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  sl_bus_arbiter #(.NUM_REQ(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .grant(grant_a),
    .grant_idx(idx_a), .busy(busy_a), .hold_timeout(tmo_a));

  sl_bus_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3)
`ifdef SL_ARB_TIMEOUT_EN
    , .HOLD_MAX(16)
`endif
  ) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .grant(grant_b),
    .grant_idx(idx_b), .busy(busy_b), .hold_timeout(tmo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = none), edges since release, previous winner, cycles held, revoke mask.
  int         m_own[2], m_since[2], m_last[2], m_held[2];
  bit         m_tmo[2];
  logic [3:0] m_mask[2];
  int         gap_of[2]  = '{1, 3};
  int         hold_of[2] = '{4096, 16};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_since[k] = 1000; m_last[k] = 3;
      m_held[k] = 0; m_tmo[k] = 1'b0; m_mask[k] = 4'b0000;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    logic [3:0] nm;
    nm = m_mask[k] & r;
    m_tmo[k] = 1'b0;
    if (m_own[k] >= 0) begin
      if (!r[m_own[k]]) begin
        m_own[k] = -1; m_since[k] = 0;
      end else if (TMO_EN && m_held[k] >= hold_of[k]) begin
        nm[m_own[k]] = 1'b1; m_tmo[k] = 1'b1; m_own[k] = -1; m_since[k] = 0;
      end else m_held[k]++;
    end else begin
      if (m_since[k] < 1000) m_since[k]++;
      if (m_since[k] >= gap_of[k]) begin
        for (int s = 1; s <= 4; s++) begin
          int i;
          i = (m_last[k] + s) % 4;
          if (m_own[k] < 0 && r[i] && !(TMO_EN && m_mask[k][i])) begin
            m_own[k] = i; m_last[k] = i; m_held[k] = 1;
          end
        end
      end
    end
    if (TMO_EN) m_mask[k] = nm;
  endtask

  function automatic logic [3:0] exp_g(input int k);
    return (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      req_sa = 4'b0000;
    end else begin
      req_sa = req_a;
      model_step(0, req_a);
      model_step(1, req_b);
    end
  end

  task automatic cmp(input int k, input string p, input logic [3:0] g, input logic [2:0] ix,
                     input logic b, input logic t);
    check({p, "_grant"}, g, exp_g(k));
    check({p, "_busy"}, b, (m_own[k] >= 0));
    check({p, "_timeout"}, t, m_tmo[k]);
    if (m_own[k] >= 0) check({p, "_idx"}, ix, m_own[k]);
  endtask

  logic [3:0] prev_g;
  int         wcnt[4];

  always @(negedge clk) begin
    cmp(0, "a", grant_a, idx_a, busy_a, tmo_a);
    cmp(1, "b", grant_b, idx_b, busy_b, tmo_b);
    if (reset) begin
      prev_g = 4'b0000;
      for (int i = 0; i < 4; i++) wcnt[i] = 0;
    end else begin
      if (prev_g != 4'b0000 && grant_a != 4'b0000) check("a_no_switch", grant_a, prev_g);
      if (prev_g == 4'b0000 && grant_a != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (grant_a[i]) wcnt[i] = 0;
          else if (req_sa[i]) begin
            wcnt[i]++;
            check("a_starve", (wcnt[i] <= 3), 1);
          end
        end
      end
      for (int i = 0; i < 4; i++) if (!req_sa[i]) wcnt[i] = 0;
      prev_g = grant_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int n, j, hi, tmo_seen;
    reset = 1'b1; req_a = 4'b0000; req_b = 4'b0000;
    #1;
    do_reset();
    check("rst_grant", grant_a, 4'b0000);
    check("rst_busy", busy_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_timeout", tmo_a, 0);

    // 1: basic grant, release, one gap cycle, next grant
    req_a = 4'b0101; tick();
    check("t1_first", grant_a, 4'b0001);
    tick(); tick();
    req_a = 4'b0100; tick();
    check("t1_release", grant_a, 4'b0000);
    tick();
    check("t1_second", grant_a, 4'b0100);
    check("t1_second_idx", idx_a, 2);
    req_a = 4'b0000; tick(); tick(); tick();

    // 2: all requesting, owners release and re-assert -> rotation
    do_reset();
    req_a = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (grant_a == 4'b0000 && n < 20) begin tick(); n++; end
      check("t2_order", grant_a, (32'd1 << exp_order[g]));
      j = exp_order[g];
      repeat (10) tick();
      req_a[j] = 1'b0; tick(); tick();
      req_a[j] = 1'b1;
    end
    req_a = 4'b0000; repeat (4) tick();

    // 3: GAP_CYCLES=3, request present only during the gap is not served
    do_reset();
    req_b = 4'b0010; tick();
    check("t3_grant1", grant_b, 4'b0010);
    req_b = 4'b0011; tick(); tick();
    check("t3_ignore", grant_b, 4'b0010);
    req_b = 4'b0001; tick();
    check("t3_gap1", busy_b, 0);
    req_b = 4'b0101; tick();
    check("t3_gap2", busy_b, 0);
    tick();
    check("t3_gap3", busy_b, 0);
    req_b = 4'b0001; tick();
    check("t3_after_gap", grant_b, 4'b0001);
    req_b = 4'b0000; repeat (5) tick();

    // 4: async reset mid-grant, round-robin pointer returns to NUM_REQ-1
    do_reset();
    req_a = 4'b0010; tick();
    check("t4_grant", grant_a, 4'b0010);
    #1 reset = 1'b1;
    #1 check("t4_async_grant", grant_a, 4'b0000);
    check("t4_async_busy", busy_a, 0);
    req_a = 4'b1010;
    @(posedge clk); #3 reset = 1'b0;
    tick();
    check("t4_after_reset", grant_a, 4'b0010);
    req_a = 4'b0000; repeat (3) tick();

`ifdef SL_ARB_TIMEOUT_EN
    // 5: stuck requester revoked after HOLD_MAX cycles and masked until it drops
    do_reset();
    req_b = 4'b1000; tick();
    check("t5_grant", grant_b, 4'b1000);
    hi = 1; tmo_seen = 0; n = 0;
    while (grant_b != 4'b0000 && n < 40) begin
      tick(); n++;
      if (grant_b != 4'b0000) hi++;
      if (tmo_b) tmo_seen++;
    end
    check("t5_hold_len", hi, 16);
    check("t5_tmo_now", tmo_b, 1);
    repeat (6) begin
      tick();
      if (tmo_b) tmo_seen++;
      check("t5_masked", grant_b, 4'b0000);
    end
    check("t5_tmo_once", tmo_seen, 1);
    req_b = 4'b1010; tick();
    check("t5_req1", grant_b, 4'b0010);
    req_b = 4'b1000; tick(); repeat (4) tick();
    check("t5_still_masked", grant_b, 4'b0000);
    req_b = 4'b0000; tick();
    req_b = 4'b1000; tick();
    check("t5_regrant", grant_b, 4'b1000);
    req_b = 4'b0000; repeat (5) tick();
`endif

    // 6: random traffic, model compare plus no-switch and starvation checks
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) req_a[i] = ~req_a[i];
      tick();
    end
    req_a = 4'b0000; repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
